// File: rtl/entulho_pkg.sv
// Shared definitions for the debris (entulho) weight-memory sequencer.
//
// Contents:
//   - grid geometry and datapath widths
//   - FSM state encoding
//   - cell_addr(): (linha, coluna) -> linear memory address, 1-based coordinates
package entulho_pkg;

  localparam int unsigned LINHAS  = 10;  // grid rows, 1-based
  localparam int unsigned COLUNAS = 20;  // grid columns, 1-based
  localparam int unsigned PESO_W  = 2;   // weight width
  localparam int unsigned ADDR_W  = 8;   // memory address width
  localparam int unsigned TOTAL_W = 10;  // running total, up to 200*3 = 600
  localparam int unsigned COORD_W = 5;   // coordinate port width

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWt,
    StWr,
    StFin
  } state_e;

  // 20*(linha-1) + (coluna-1), evaluated modulo 2^ADDR_W so that out-of-range
  // coordinates wrap instead of needing a wider datapath.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] linha,
                                                  input logic [COORD_W-1:0] coluna);
    logic [ADDR_W-1:0] lin0;
    logic [ADDR_W-1:0] col0;
    lin0 = ADDR_W'(linha) - ADDR_W'(1);
    col0 = ADDR_W'(coluna) - ADDR_W'(1);
    return lin0 * ADDR_W'(COLUNAS) + col0;
  endfunction

endpackage

// File: rtl/entulho_addr.sv
// Coordinate-to-address mapping shared by the load and removal ports.
//
// Ports:
//   linha, coluna : 1-based cell coordinates
//   addr          : linear memory address (wraps modulo 2^ADDR_W)
//   in_range      : 1 when 1 <= linha <= LINHAS and 1 <= coluna <= COLUNAS
module entulho_addr
  import entulho_pkg::*;
(
  input  logic [COORD_W-1:0] linha,
  input  logic [COORD_W-1:0] coluna,
  output logic [ADDR_W-1:0]  addr,
  output logic               in_range
);

  always_comb begin
    addr     = cell_addr(linha, coluna);
    in_range = (linha != '0) && (linha <= COORD_W'(LINHAS)) &&
               (coluna != '0) && (coluna <= COORD_W'(COLUNAS));
  end

endmodule

// File: rtl/entulho_ctrl.sv
// Sequencer for the external single-port debris weight memory (10x20 grid of 2-bit
// weights). Arbitrates a load port (map initialisation, fixed priority) against the
// robot's removal port; every accepted request runs a read-modify-write and keeps a
// running total of the debris left on the map.
//
// Ports:
//   clock, reset                    : rising-edge clock, async active-low reset
//   load_valid/linha/coluna/peso    : load request, held until load_done
//   load_done                       : one-cycle pulse when a load commits
//   rem_req/linha/coluna            : removal request, held until rem_ack
//   rem_ack, rem_peso               : removal done pulse and weight left at the cell
//   mem_addr/re/we/wdata, mem_rdata : memory port, read data one cycle after mem_re
//   busy                            : high in every state except idle
//   total_peso                      : sum of all weights written through this block
//   err                             : one-cycle pulse on a rejected request
//
// Build option: define ENTULHO_RANGE_CHECK_EN to reject out-of-grid coordinates
// (err pulse, then done/ack with no memory access). Without it the address wraps
// and err is tied to 0.
//
// Timing: accept in cycle N, mem_re in N+1, read data captured in N+2, mem_we in
// N+3, done/ack in N+4, idle again in N+5. All outputs come straight from flops.
module entulho_ctrl
  import entulho_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load_valid,
  input  logic [COORD_W-1:0] load_linha,
  input  logic [COORD_W-1:0] load_coluna,
  input  logic [PESO_W-1:0]  load_peso,
  output logic               load_done,
  input  logic               rem_req,
  input  logic [COORD_W-1:0] rem_linha,
  input  logic [COORD_W-1:0] rem_coluna,
  output logic               rem_ack,
  output logic [PESO_W-1:0]  rem_peso,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_re,
  output logic               mem_we,
  output logic [PESO_W-1:0]  mem_wdata,
  input  logic [PESO_W-1:0]  mem_rdata,
  output logic               busy,
  output logic [TOTAL_W-1:0] total_peso,
  output logic               err
);

  state_e state_q, state_d;

  logic               op_is_load_q, op_is_load_d;
  logic               bad_q, bad_d;
  logic [PESO_W-1:0]  peso_q, peso_d;
  logic [PESO_W-1:0]  old_q, old_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  logic               mem_re_q, mem_re_d;
  logic               mem_we_q, mem_we_d;
  logic [PESO_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               load_done_q, load_done_d;
  logic               rem_ack_q, rem_ack_d;
  logic [PESO_W-1:0]  rem_peso_q, rem_peso_d;
  logic               busy_q, busy_d;

  logic               accept;
  logic [COORD_W-1:0] sel_linha, sel_coluna;
  logic [ADDR_W-1:0]  sel_addr;
  logic               in_range;
  logic               bad_req;
  logic [TOTAL_W:0]   load_sum;
  logic [TOTAL_W:0]   old_ext;

  assign accept = (state_q == StIdle) && (load_valid || rem_req);

  // Load wins when both ports request in the same idle cycle.
  assign sel_linha  = load_valid ? load_linha  : rem_linha;
  assign sel_coluna = load_valid ? load_coluna : rem_coluna;

  entulho_addr u_addr (
    .linha    (sel_linha),
    .coluna   (sel_coluna),
    .addr     (sel_addr),
    .in_range (in_range)
  );

`ifdef ENTULHO_RANGE_CHECK_EN
  assign bad_req = ~in_range;
`else
  assign bad_req = 1'b0;
  logic unused_in_range;
  assign unused_in_range = in_range;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (load_valid || rem_req) state_d = StRd;
      // A rejected request skips the memory and goes straight to the done pulse.
      StRd:    state_d = bad_q ? StFin : StWt;
      StWt:    state_d = StWr;
      StWr:    state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operation context and running total
  // ---------------------------------------------------------------------------
  assign load_sum = {1'b0, total_q} + {{(TOTAL_W + 1 - PESO_W){1'b0}}, peso_q};
  assign old_ext  = {{(TOTAL_W + 1 - PESO_W){1'b0}}, old_q};

  always_comb begin
    op_is_load_d = accept ? load_valid : op_is_load_q;
    bad_d        = accept ? bad_req    : bad_q;
    peso_d       = accept ? load_peso  : peso_q;
    addr_d       = accept ? sel_addr   : addr_q;
    old_d        = (state_q == StWt) ? mem_rdata : old_q;

    total_d = total_q;
    if (state_q == StWr) begin
      if (op_is_load_q) begin
        // total - old + new, clamped at 0 when the memory held weight that was
        // loaded before the last reset.
        total_d = (load_sum < old_ext) ? '0 : TOTAL_W'(load_sum - old_ext);
      end else if ((old_q != '0) && (total_q != '0)) begin
        total_d = total_q - TOTAL_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_is_load_q <= 1'b0;
      bad_q        <= 1'b0;
      peso_q       <= '0;
      addr_q       <= '0;
      old_q        <= '0;
      total_q      <= '0;
    end else begin
      op_is_load_q <= op_is_load_d;
      bad_q        <= bad_d;
      peso_q       <= peso_d;
      addr_q       <= addr_d;
      old_q        <= old_d;
      total_q      <= total_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the output flops, decoded from the next state
  // so every strobe lines up with the state it belongs to.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d      = (state_d != StIdle);
    mem_re_d    = (state_d == StRd) && !bad_d;
    // Removal of an empty cell performs no write.
    mem_we_d    = (state_d == StWr) && (op_is_load_q || (old_d != '0));
    mem_wdata_d = '0;
    if (mem_we_d) begin
      mem_wdata_d = op_is_load_q ? peso_q : old_d - PESO_W'(1);
    end
    load_done_d = (state_d == StFin) && op_is_load_q;
    rem_ack_d   = (state_d == StFin) && !op_is_load_q;
    rem_peso_d  = '0;
    if (rem_ack_d && !bad_q && (old_q != '0)) begin
      rem_peso_d = old_q - PESO_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q      <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      load_done_q <= 1'b0;
      rem_ack_q   <= 1'b0;
      rem_peso_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      load_done_q <= load_done_d;
      rem_ack_q   <= rem_ack_d;
      rem_peso_q  <= rem_peso_d;
    end
  end

`ifdef ENTULHO_RANGE_CHECK_EN
  logic err_q, err_d;

  // err fires in the cycle a rejected request would otherwise have read memory.
  assign err_d = (state_d == StRd) && bad_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy       = busy_q;
  assign mem_addr   = addr_q;
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign load_done  = load_done_q;
  assign rem_ack    = rem_ack_q;
  assign rem_peso   = rem_peso_q;
  assign total_peso = total_q;

endmodule

// File: tb/tb_entulho_ctrl.sv
// Directed bench for entulho_ctrl with a behavioural single-port memory.
module tb_entulho_ctrl;
  import entulho_pkg::*;

  logic               clock = 1'b0;
  logic               reset;
  logic               load_valid;
  logic [COORD_W-1:0] load_linha, load_coluna;
  logic [PESO_W-1:0]  load_peso;
  logic               load_done;
  logic               rem_req;
  logic [COORD_W-1:0] rem_linha, rem_coluna;
  logic               rem_ack;
  logic [PESO_W-1:0]  rem_peso;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_re, mem_we;
  logic [PESO_W-1:0]  mem_wdata;
  logic [PESO_W-1:0]  mem_rdata = '0;
  logic               busy;
  logic [TOTAL_W-1:0] total_peso;
  logic               err;

  logic [PESO_W-1:0]  mem [256] = '{default: '0};

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  entulho_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_linha  (load_linha),
    .load_coluna (load_coluna),
    .load_peso   (load_peso),
    .load_done   (load_done),
    .rem_req     (rem_req),
    .rem_linha   (rem_linha),
    .rem_coluna  (rem_coluna),
    .rem_ack     (rem_ack),
    .rem_peso    (rem_peso),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .total_peso  (total_peso),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle, ends at the negedge of cycle N+5.
  task automatic do_op(input string nm, input logic is_load, input logic [4:0] l,
                       input logic [4:0] c, input logic [1:0] p, input logic [7:0] e_addr,
                       input logic e_we, input logic [1:0] e_wdata, input logic [1:0] e_peso,
                       input logic [9:0] e_total);
    if (is_load) begin
      load_valid = 1'b1; load_linha = l; load_coluna = c; load_peso = p;
    end else begin
      rem_req = 1'b1; rem_linha = l; rem_coluna = c;
    end
    @(negedge clock);  // N+1: read
    chk({nm, "/rd_re"}, mem_re, 1);
    chk({nm, "/rd_addr"}, mem_addr, e_addr);
    chk({nm, "/rd_busy"}, busy, 1);
    chk({nm, "/rd_err"}, err, 0);
    // Drop and scramble the request: the operation must run on captured values.
    if (is_load) begin
      load_valid = 1'b0; load_peso = ~p; load_linha = '0;
    end else begin
      rem_req = 1'b0; rem_linha = '0;
    end
    @(negedge clock);  // N+2: wait for read data
    chk({nm, "/wt_re"}, mem_re, 0);
    chk({nm, "/wt_we"}, mem_we, 0);
    @(negedge clock);  // N+3: write
    chk({nm, "/wr_we"}, mem_we, e_we);
    chk({nm, "/wr_re"}, mem_re, 0);
    chk({nm, "/wr_addr"}, mem_addr, e_addr);
    if (e_we) chk({nm, "/wr_wdata"}, mem_wdata, e_wdata);
    @(negedge clock);  // N+4: done/ack
    chk({nm, "/fin_done"}, load_done, is_load);
    chk({nm, "/fin_ack"}, rem_ack, !is_load);
    chk({nm, "/fin_peso"}, rem_peso, e_peso);
    chk({nm, "/fin_total"}, total_peso, e_total);
    chk({nm, "/fin_we"}, mem_we, 0);
    @(negedge clock);  // N+5: idle again
    chk({nm, "/idle_busy"}, busy, 0);
    chk({nm, "/idle_done"}, load_done | rem_ack, 0);
  endtask

`ifdef ENTULHO_RANGE_CHECK_EN
  task automatic bad_op(input string nm, input logic is_load, input logic [4:0] l,
                        input logic [4:0] c, input logic [9:0] e_total);
    if (is_load) begin
      load_valid = 1'b1; load_linha = l; load_coluna = c; load_peso = 2'd3;
    end else begin
      rem_req = 1'b1; rem_linha = l; rem_coluna = c;
    end
    @(negedge clock);
    chk({nm, "/err"}, err, 1);
    chk({nm, "/err_re"}, mem_re, 0);
    chk({nm, "/err_busy"}, busy, 1);
    chk({nm, "/err_early_done"}, load_done | rem_ack, 0);
    load_valid = 1'b0;
    rem_req    = 1'b0;
    @(negedge clock);
    chk({nm, "/done_err"}, err, 0);
    chk({nm, "/done_done"}, load_done, is_load);
    chk({nm, "/done_ack"}, rem_ack, !is_load);
    chk({nm, "/done_peso"}, rem_peso, 0);
    chk({nm, "/done_re"}, mem_re, 0);
    chk({nm, "/done_we"}, mem_we, 0);
    chk({nm, "/done_total"}, total_peso, e_total);
    @(negedge clock);
    chk({nm, "/idle_busy"}, busy, 0);
    chk({nm, "/idle_we"}, mem_we, 0);
  endtask
`endif

  initial begin
    reset = 1'b0;
    load_valid = 1'b0; load_linha = '0; load_coluna = '0; load_peso = '0;
    rem_req = 1'b0; rem_linha = '0; rem_coluna = '0;
    #1;
    chk("rst/busy", busy, 0);
    chk("rst/total", total_peso, 0);
    chk("rst/strobes", {mem_re, mem_we, load_done, rem_ack, err}, 0);
    chk("rst/addr", mem_addr, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Load, then drain the cell one unit at a time.
    do_op("load_10_1", 1'b1, 5'd10, 5'd1, 2'd3, 8'd180, 1'b1, 2'd3, 2'd0, 10'd3);
    do_op("rem1", 1'b0, 5'd10, 5'd1, 2'd0, 8'd180, 1'b1, 2'd2, 2'd2, 10'd2);
    do_op("rem2", 1'b0, 5'd10, 5'd1, 2'd0, 8'd180, 1'b1, 2'd1, 2'd1, 10'd1);
    do_op("rem3", 1'b0, 5'd10, 5'd1, 2'd0, 8'd180, 1'b1, 2'd0, 2'd0, 10'd0);
    do_op("rem_empty", 1'b0, 5'd10, 5'd1, 2'd0, 8'd180, 1'b0, 2'd0, 2'd0, 10'd0);

    // Reload semantics: total tracks old -> new.
    do_op("load_1_1", 1'b1, 5'd1, 5'd1, 2'd2, 8'd0, 1'b1, 2'd2, 2'd0, 10'd2);
    do_op("reload_1_1", 1'b1, 5'd1, 5'd1, 2'd1, 8'd0, 1'b1, 2'd1, 2'd0, 10'd1);
    do_op("load0_2_3", 1'b1, 5'd2, 5'd3, 2'd0, 8'd22, 1'b1, 2'd0, 2'd0, 10'd1);

    // Both ports in the same idle cycle: load first, removal accepted at N+5.
    rem_req = 1'b1; rem_linha = 5'd1; rem_coluna = 5'd1;
    do_op("prio_load", 1'b1, 5'd3, 5'd4, 2'd3, 8'd43, 1'b1, 2'd3, 2'd0, 10'd4);
    do_op("prio_rem", 1'b0, 5'd1, 5'd1, 2'd0, 8'd0, 1'b1, 2'd0, 2'd0, 10'd3);

    // Reset while waiting for read data.
    rem_req = 1'b1; rem_linha = 5'd3; rem_coluna = 5'd4;
    @(negedge clock);
    chk("rstmid/rd_re", mem_re, 1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rstmid/busy", busy, 0);
    chk("rstmid/total", total_peso, 0);
    chk("rstmid/strobes", {mem_re, mem_we, load_done, rem_ack, err}, 0);
    chk("rstmid/addr", mem_addr, 0);
    chk("rstmid/data", {mem_wdata, rem_peso}, 0);
    @(negedge clock);
    chk("rstmid/held_we", mem_we, 0);
    chk("rstmid/held_ack", rem_ack, 0);
    reset = 1'b1;
    // Request still high: fresh removal; cell untouched (3), total saturates at 0.
    do_op("rstmid_rem", 1'b0, 5'd3, 5'd4, 2'd0, 8'd43, 1'b1, 2'd2, 2'd2, 10'd0);

`ifdef ENTULHO_RANGE_CHECK_EN
    bad_op("bad_rem_0_5", 1'b0, 5'd0, 5'd5, 10'd0);
    bad_op("bad_rem_11_3", 1'b0, 5'd11, 5'd3, 10'd0);
    bad_op("bad_load_2_21", 1'b1, 5'd2, 5'd21, 10'd0);
`else
    // No range check: address wraps modulo 256, cells are empty, no write.
    do_op("wrap_rem_0_5", 1'b0, 5'd0, 5'd5, 2'd0, 8'd240, 1'b0, 2'd0, 2'd0, 10'd0);
    do_op("wrap_rem_11_3", 1'b0, 5'd11, 5'd3, 2'd0, 8'd202, 1'b0, 2'd0, 2'd0, 10'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
